// File: rtl/tahmin_oyunu_pkg.sv
// Shared definitions for the grid guessing game: game state encodings and
// the default cell-value table (entry i = row*SUTUN+col holds value i).
package tahmin_oyunu_pkg;

    typedef enum logic [1:0] {
        BOSTA    = 2'b00,
        OYUN     = 2'b01,
        KAZANDI  = 2'b10,
        KAYBETTI = 2'b11
    } durum_t;

    localparam logic [63:0] TABLO_VARSAYILAN = 64'hFEDCBA9876543210;

endpackage

// File: rtl/tahmin_oyunu_tablo.sv
// tahmin_tablo: combinational cell-value lookup, reusable by display logic.
// Ports:
//   row   in  $clog2(SATIR)  grid row
//   col   in  $clog2(SUTUN)  grid column
//   value out VERI_W         TABLO entry at row*SUTUN+col
module tahmin_tablo
    import tahmin_oyunu_pkg::*;
#(
    parameter int unsigned SATIR  = 4,
    parameter int unsigned SUTUN  = 4,
    parameter int unsigned VERI_W = 4,
    parameter logic [SATIR*SUTUN*VERI_W-1:0] TABLO = TABLO_VARSAYILAN
) (
    input  logic [$clog2(SATIR)-1:0] row,
    input  logic [$clog2(SUTUN)-1:0] col,
    output logic [VERI_W-1:0]        value
);

    localparam int unsigned IDX_W = $clog2(SATIR * SUTUN);

    logic [IDX_W-1:0] idx;

    // Row-major flat index; row/col are always in range, so no bounds guard.
    assign idx   = IDX_W'(row) * IDX_W'(SUTUN) + IDX_W'(col);
    assign value = TABLO[idx*VERI_W +: VERI_W];

endmodule

// File: rtl/tahmin_oyunu.sv
// tahmin_oyunu: sequential grid guessing game.
// The player steps right/down over a SATIR x SUTUN grid; each confirm
// compares the current cell value against a hidden number latched at start.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   baslat, sayi      start/restart pulse and hidden number sampled with it
//   sag, asagi        single-step right/down pulses
//   onayla            confirm current cell as a guess
//   konum_sag/asagi   current column/row
//   sayi_tahmin       table value at current cell (combinational from position)
//   tahmin_dogru/yanlis  one-cycle result pulses
//   kalan_hak         remaining attempts
//   durum             00 BOSTA, 01 OYUN, 10 KAZANDI, 11 KAYBETTI
//   skor              saturating count of games won since reset
module tahmin_oyunu
    import tahmin_oyunu_pkg::*;
#(
    parameter int unsigned SATIR  = 4,
    parameter int unsigned SUTUN  = 4,
    parameter int unsigned VERI_W = 4,
    parameter int unsigned HAK    = 3,
    parameter int unsigned SKOR_W = 8,
    parameter logic [SATIR*SUTUN*VERI_W-1:0] TABLO = TABLO_VARSAYILAN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       baslat,
    input  logic [VERI_W-1:0]          sayi,
    input  logic                       sag,
    input  logic                       asagi,
    input  logic                       onayla,
    output logic [$clog2(SUTUN)-1:0]   konum_sag,
    output logic [$clog2(SATIR)-1:0]   konum_asagi,
    output logic [VERI_W-1:0]          sayi_tahmin,
    output logic                       tahmin_dogru,
    output logic                       tahmin_yanlis,
    output logic [$clog2(HAK+1)-1:0]   kalan_hak,
    output logic [1:0]                 durum,
    output logic [SKOR_W-1:0]          skor
);

    localparam int unsigned COL_W = $clog2(SUTUN);
    localparam int unsigned ROW_W = $clog2(SATIR);
    localparam int unsigned HAK_W = $clog2(HAK + 1);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(SUTUN - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(SATIR - 1);

    durum_t              state_q, state_d;
    logic [VERI_W-1:0]   hidden_q, hidden_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [HAK_W-1:0]    hak_q, hak_d;
    logic [SKOR_W-1:0]   skor_q, skor_d;
    logic                dogru_q, dogru_d;
    logic                yanlis_q, yanlis_d;
    logic [VERI_W-1:0]   cell_value;

    // Cell value follows the registered position with no added latency.
    tahmin_tablo #(
        .SATIR  (SATIR),
        .SUTUN  (SUTUN),
        .VERI_W (VERI_W),
        .TABLO  (TABLO)
    ) u_tablo (
        .row   (row_q),
        .col   (col_q),
        .value (cell_value)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BOSTA;
            hidden_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            hak_q    <= '0;
            skor_q   <= '0;
            dogru_q  <= 1'b0;
            yanlis_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hidden_q <= hidden_d;
            col_q    <= col_d;
            row_q    <= row_d;
            hak_q    <= hak_d;
            skor_q   <= skor_d;
            dogru_q  <= dogru_d;
            yanlis_q <= yanlis_d;
        end
    end

    // Next-state and next-value logic; baslat overrides everything else,
    // and a confirm in play drops any move issued in the same cycle.
    always_comb begin
        state_d  = state_q;
        hidden_d = hidden_q;
        col_d    = col_q;
        row_d    = row_q;
        hak_d    = hak_q;
        skor_d   = skor_q;
        dogru_d  = 1'b0;
        yanlis_d = 1'b0;

        if (baslat) begin
            state_d  = OYUN;
            hidden_d = sayi;
            col_d    = '0;
            row_d    = '0;
            hak_d    = HAK_W'(HAK);
        end else if (state_q == OYUN) begin
            if (onayla) begin
                if (cell_value == hidden_q) begin
                    dogru_d = 1'b1;
                    state_d = KAZANDI;
                    if (!(&skor_q)) begin
                        skor_d = skor_q + SKOR_W'(1);
                    end
                end else begin
                    yanlis_d = 1'b1;
                    hak_d    = hak_q - HAK_W'(1);
                    if (hak_q == HAK_W'(1)) begin
                        state_d = KAYBETTI;
                    end
                end
            end else begin
                if (sag && (col_q != COL_MAX)) begin
                    col_d = col_q + COL_W'(1);
                end
                if (asagi && (row_q != ROW_MAX)) begin
                    row_d = row_q + ROW_W'(1);
                end
            end
        end
    end

    assign konum_sag     = col_q;
    assign konum_asagi   = row_q;
    assign sayi_tahmin   = cell_value;
    assign tahmin_dogru  = dogru_q;
    assign tahmin_yanlis = yanlis_q;
    assign kalan_hak     = hak_q;
    assign durum         = state_q;
    assign skor          = skor_q;

endmodule

// File: tb/tb_tahmin_oyunu.sv
// Testbench for tahmin_oyunu: directed scenarios with literal expectations,
// then randomized play checked every cycle against a behavioural game model.
module tb_tahmin_oyunu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baslat = 1'b0;
    logic [3:0] sayi = '0;
    logic       sag = 1'b0;
    logic       asagi = 1'b0;
    logic       onayla = 1'b0;
    logic [1:0] konum_sag;
    logic [1:0] konum_asagi;
    logic [3:0] sayi_tahmin;
    logic       tahmin_dogru;
    logic       tahmin_yanlis;
    logic [1:0] kalan_hak;
    logic [1:0] durum;
    logic [7:0] skor;

    int n_chk  = 0;
    int n_fail = 0;

    tahmin_oyunu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .baslat        (baslat),
        .sayi          (sayi),
        .sag           (sag),
        .asagi         (asagi),
        .onayla        (onayla),
        .konum_sag     (konum_sag),
        .konum_asagi   (konum_asagi),
        .sayi_tahmin   (sayi_tahmin),
        .tahmin_dogru  (tahmin_dogru),
        .tahmin_yanlis (tahmin_yanlis),
        .kalan_hak     (kalan_hak),
        .durum         (durum),
        .skor          (skor)
    );

    always #5 clk = ~clk;

    // Behavioural game model: game phase 0 idle, 1 playing, 2 won, 3 lost.
    // With the default table, the cell value is simply row*4+col.
    int m_row, m_col, m_hak, m_phase, m_skor, m_hidden, m_dogru, m_yanlis;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_row <= 0; m_col <= 0; m_hak <= 0; m_phase <= 0;
            m_skor <= 0; m_hidden <= 0; m_dogru <= 0; m_yanlis <= 0;
        end else begin
            m_dogru  <= 0;
            m_yanlis <= 0;
            if (baslat) begin
                m_hidden <= int'(sayi);
                m_row <= 0; m_col <= 0; m_hak <= 3; m_phase <= 1;
            end else if (m_phase == 1 && onayla) begin
                if (m_row * 4 + m_col == m_hidden) begin
                    m_dogru <= 1;
                    m_phase <= 2;
                    m_skor  <= (m_skor < 255) ? m_skor + 1 : 255;
                end else begin
                    m_yanlis <= 1;
                    m_hak    <= m_hak - 1;
                    if (m_hak - 1 == 0) m_phase <= 3;
                end
            end else if (m_phase == 1) begin
                m_col <= (m_col + int'(sag)   > 3) ? 3 : m_col + int'(sag);
                m_row <= (m_row + int'(asagi) > 3) ? 3 : m_row + int'(asagi);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, just after the active edge.
    always @(posedge clk) begin
        #1;
        chk("durum",        int'(durum),         m_phase);
        chk("konum_sag",    int'(konum_sag),     m_col);
        chk("konum_asagi",  int'(konum_asagi),   m_row);
        chk("sayi_tahmin",  int'(sayi_tahmin),   m_row * 4 + m_col);
        chk("kalan_hak",    int'(kalan_hak),     m_hak);
        chk("skor",         int'(skor),          m_skor);
        chk("tahmin_dogru", int'(tahmin_dogru),  m_dogru);
        chk("tahmin_yanlis", int'(tahmin_yanlis), m_yanlis);
        chk("pulse_excl",   int'(tahmin_dogru & tahmin_yanlis), 0);
    end

    // One-cycle input pulse; returns at the following falling edge.
    task automatic pulse(input logic b, input logic [3:0] s, input logic r,
                         input logic d, input logic o);
        @(negedge clk);
        baslat = b; sayi = s; sag = r; asagi = d; onayla = o;
        @(negedge clk);
        baslat = 1'b0; sag = 1'b0; asagi = 1'b0; onayla = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_durum", int'(durum), 0);
        chk("rst_konum", int'({konum_asagi, konum_sag}), 0);
        chk("rst_tahmin", int'(sayi_tahmin), 0);
        chk("rst_hak", int'(kalan_hak), 0);
        chk("rst_skor", int'(skor), 0);
        chk("rst_pulses", int'({tahmin_dogru, tahmin_yanlis}), 0);
        rst_n = 1'b1;

        // Win path
        pulse(1, 4'd6, 0, 0, 0);
        pulse(0, 0, 0, 1, 0);
        pulse(0, 0, 1, 0, 0);
        pulse(0, 0, 1, 0, 0);
        chk("win_col", int'(konum_sag), 2);
        chk("win_row", int'(konum_asagi), 1);
        chk("win_val", int'(sayi_tahmin), 6);
        pulse(0, 0, 0, 0, 1);
        chk("win_dogru", int'(tahmin_dogru), 1);
        chk("win_durum", int'(durum), 2);
        chk("win_skor", int'(skor), 1);
        @(negedge clk);
        chk("win_dogru_off", int'(tahmin_dogru), 0);

        // Lose path
        pulse(1, 4'd15, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            pulse(0, 0, 0, 0, 1);
            chk("lose_yanlis", int'(tahmin_yanlis), 1);
            chk("lose_hak", int'(kalan_hak), 2 - i);
        end
        chk("lose_durum", int'(durum), 3);
        pulse(0, 0, 1, 0, 0);
        chk("lose_frozen", int'(konum_sag), 0);

        // Saturation
        pulse(1, 4'd0, 0, 0, 0);
        repeat (5) pulse(0, 0, 1, 0, 0);
        repeat (6) pulse(0, 0, 0, 1, 0);
        chk("sat_konum", int'({konum_asagi, konum_sag}), 15);
        chk("sat_val", int'(sayi_tahmin), 15);
        pulse(1, 4'd0, 0, 0, 0);
        pulse(0, 0, 1, 1, 0);
        chk("diag_val", int'(sayi_tahmin), 5);

        // Simultaneous confirm + move, then restart with confirm
        pulse(1, 4'd0, 0, 0, 0);
        pulse(0, 0, 1, 0, 1);
        chk("sim_dogru", int'(tahmin_dogru), 1);
        chk("sim_col", int'(konum_sag), 0);
        chk("sim_skor", int'(skor), 2);
        pulse(1, 4'd9, 0, 0, 0);
        pulse(1, 4'd9, 0, 0, 1);
        chk("restart_durum", int'(durum), 1);
        chk("restart_hak", int'(kalan_hak), 3);
        chk("restart_skor", int'(skor), 2);
        chk("restart_pulse", int'({tahmin_dogru, tahmin_yanlis}), 0);

        // Asynchronous reset mid-game, observed before the next rising edge
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_durum", int'(durum), 0);
        chk("arst_skor", int'(skor), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized play
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            baslat = ($urandom_range(0, 15) == 0);
            sayi   = 4'($urandom_range(0, 15));
            sag    = ($urandom_range(0, 2) == 0);
            asagi  = ($urandom_range(0, 2) == 0);
            onayla = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        baslat = 1'b0; sag = 1'b0; asagi = 1'b0; onayla = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
